// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {bout, diff} = a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst (async high), start/a/b/bin in; busy, done (1-cycle pulse), diff, bout out.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q, busy_q, done_q, bout_q;

    logic             d_bit;
    logic             brw_d;
    logic [WIDTH-1:0] res_d;

    // Single full-subtractor cell on the current LSBs.
    always_comb begin
        d_bit = sa_q[0] ^ sb_q[0] ^ brw_q;
        brw_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
        res_d = {d_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    // DONE accepts start the same way IDLE does (back-to-back).
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        brw_q   <= bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    brw_q <= brw_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Last bit: publish result in the same edge it is formed.
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        bout_q  <= brw_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8).
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done.
    // cyc = rising edges after the start edge until done seen.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vbin, output int cyc,
                          output int busy_cnt);
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; bin = ~vbin;
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 8'h12; b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b want 0 0 00 0",
                     busy, done, diff, bout);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_start: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int cyc, bc;
        run_op(8'd100, 8'd37, 1'b0, cyc, bc);
        tests++;
        if (cyc !== 8) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 8", cyc);
        end
        tests++;
        if (bc !== 8) begin
            fails++;
            $display("FAIL basic_busy: got %0d want 8", bc);
        end
        tests++;
        if (diff !== 8'h3F || bout !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: diff=%h bout=%b busy=%b want 3f 0 0",
                     diff, bout, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || diff !== 8'h3F) begin
            fails++;
            $display("FAIL basic_pulse: done=%b diff=%h want 0 3f", done, diff);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta [3] = '{8'd5, 8'd0, 8'hFF};
        logic [W-1:0] tb [3] = '{8'd9, 8'd0, 8'h00};
        logic         tbn[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] ed [3] = '{8'hFC, 8'hFF, 8'hFF};
        logic         eb [3] = '{1'b1, 1'b1, 1'b0};
        int cyc, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tbn[i], cyc, bc);
            tests++;
            if (cyc !== 8 || diff !== ed[i] || bout !== eb[i]) begin
                fails++;
                $display("FAIL boundary_%0d: cyc=%0d diff=%h bout=%b want 8 %h %b",
                         i, cyc, diff, bout, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        @(negedge clk);
        a = 8'd200; b = 8'd50; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd2; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                dones++;
                tests++;
                if (diff !== 8'd150 || bout !== 1'b0) begin
                    fails++;
                    $display("FAIL ignore_result: diff=%0d bout=%b want 150 0",
                             diff, bout);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL ignore_pulses: got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        run_op(8'd50, 8'd20, 1'b0, cyc, bc);
        tests++;
        if (done !== 1'b1 || diff !== 8'd30 || bout !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: done=%b diff=%0d bout=%b want 1 30 0",
                     done, diff, bout);
        end
        a = 8'd10; b = 8'd10; bin = 1'b1; start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 30);
        tests++;
        if (cyc !== 9 || diff !== 8'hFF || bout !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: cyc=%0d diff=%h bout=%b want 9 ff 1",
                     cyc, diff, bout);
        end
    endtask

    task automatic test_reset_abort();
        int dones, cyc, bc;
        @(negedge clk);
        a = 8'd77; b = 8'd11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            fails++;
            $display("FAIL abort_async: busy=%b diff=%h bout=%b want 0 00 0",
                     busy, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort_nodone: got %0d want 0", dones);
        end
        run_op(8'd77, 8'd11, 1'b0, cyc, bc);
        tests++;
        if (cyc !== 8 || diff !== 8'd66 || bout !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: cyc=%0d diff=%0d bout=%b want 8 66 0",
                     cyc, diff, bout);
        end
    endtask

    task automatic test_random();
        int cyc, bc, bad;
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W:0]   exp;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            run_op(ra, rb, rbin, cyc, bc);
            tests++;
            if (cyc !== 8 || {bout, diff} !== exp) begin
                fails++;
                if (bad < 5)
                    $display("FAIL random_%0d: a=%0d b=%0d bin=%b got %h cyc=%0d want %h",
                             i, ra, rb, rbin, {bout, diff}, cyc, exp);
                bad++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_basic();
        test_reset();
        test_boundaries();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor. Computes diff = a - b - bin (mod 2^WIDTH) and borrow-out, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a borrow flip-flop; it is the subtract-direction counterpart of the team's adder blocks.
- Sits in the arithmetic library as an area-cheap alternative to a ripple subtractor.
- Uses a start/busy/done handshake so a controller or testbench can sequence operations.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when a result is valid
- diff  output  WIDTH  registered difference; held until the next completion
- bout  output  1  registered borrow-out; held until the next completion

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst). While rst=1:
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads sa=a, sb=b, brw=bin, res=0, cnt=0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN (busy=1), at each edge:
  - d = sa[0]^sb[0]^brw.
  - brw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw).
  - res <= {d, res[WIDTH-1:1]}; sa and sb shift right by one; cnt <= cnt+1.
- RUN exit: on the edge that processes bit WIDTH-1 (edge E_WIDTH), go to DONE and load diff with the final shifted res and bout with the final brw in the same edge.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back; goes to RUN, operands captured).
  - Otherwise go to IDLE.
- Latency: done is high in the cycle that begins WIDTH edges after the start edge. Throughput is one result per WIDTH+1 cycles in back-to-back mode.
- start during RUN is ignored, and the a/b/bin inputs have no effect until the next accepted start.
- diff/bout change only on the edge that enters DONE; between completions they hold the last result.
- Arithmetic checks:
  - {bout, diff} must equal the (WIDTH+1)-bit two's-complement value a - b - bin.
  - bout=1 exactly when a < b + bin (unsigned).
- Reset mid-RUN aborts immediately. diff/bout go to 0, and no done pulse is produced for the aborted operation.
- Reset asserted in the same cycle as start: reset wins.
- Operand values 0 and 2^WIDTH-1 need no special handling; wrap-around is modulo 2^WIDTH.

Test Plan:
- WIDTH=8; start with a=100, b=37, bin=0 -> busy for 8 cycles; done pulses once in cycle 8 after the start edge; diff=63 (0x3F), bout=0.
- a=5, b=9, bin=0 -> diff=0xFC, bout=1. Then a=0, b=0, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
- Start a=200, b=50; in cycle 3 of RUN pulse start with a=1, b=2 -> second request ignored; result diff=150, bout=0; exactly one done pulse.
- Back-to-back: hold start=1 in the DONE cycle with a=10, b=10, bin=1 -> first result valid on done; second run begins immediately; second done 9 cycles after the first, with diff=0xFF, bout=1.
- Assert rst for 1 cycle in cycle 4 of RUN (a=77, b=11) -> busy=0, diff=0, bout=0 immediately (asynchronously); no done pulse; a new start then completes normally with diff=66.
- Randomized self-check: 200 operations with random a, b, bin -> every done pulse matches {bout, diff} == a - b - bin (9-bit).
